// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder and its RAM.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int unsigned BYTE_LANES = 4;

  // Expand per-lane byte enables into a per-bit write mask.
  function automatic logic [31:0] be_to_mask(input logic [BYTE_LANES-1:0] be);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < BYTE_LANES; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM with synchronous read and byte-lane write enables; not reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [BYTE_LANES-1:0] be,
  input  logic [IDX_W-1:0]      idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] mask;

  assign mask = be_to_mask(be);

  // rdata only moves on a read, so it holds across writes and idle cycles.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= (mem[idx] & ~mask) | (wdata & mask);
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, LATENCY wait states, then a one-cycle ack.
// Define MEM_RESPONDER_ERR_EN to flag misaligned and out-of-range accesses via err.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  input  logic [BYTE_LANES-1:0] be,
  output logic                  busy,
  output logic                  ack,
  output logic [31:0]           rdata,
  output logic                  err
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t                state, state_next;
  logic [3:0]            cnt, cnt_next;
  logic                  accept, access;
  logic                  lat_we;
  logic [31:0]           lat_addr, lat_wdata;
  logic [BYTE_LANES-1:0] lat_be;
  logic                  rd_zero, err_q;

  logic                  acc_we, acc_err;
  logic [31:0]           acc_addr, acc_wdata, acc_offset;
  logic [BYTE_LANES-1:0] acc_be;
  logic [IDX_W-1:0]      acc_idx;
  logic [31:0]           mem_rdata;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    access     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_next = RESP;
            access     = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = RESP;
          access     = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With zero latency the access happens on the accepting edge, straight from the inputs.
  assign acc_we     = (state == IDLE) ? we    : lat_we;
  assign acc_addr   = (state == IDLE) ? addr  : lat_addr;
  assign acc_wdata  = (state == IDLE) ? wdata : lat_wdata;
  assign acc_be     = (state == IDLE) ? be    : lat_be;
  assign acc_offset = acc_addr - BASE_ADDR;
  assign acc_idx    = IDX_W'(acc_offset >> 2);

`ifdef MEM_RESPONDER_ERR_EN
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr < BASE_ADDR) ||
                   ({1'b0, acc_addr} >= LIMIT);
`else
  assign acc_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      rd_zero   <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        lat_we    <= we;
        lat_addr  <= addr;
        lat_wdata <= wdata;
        lat_be    <= be;
      end
      if (access) begin
        err_q <= acc_err;
        if (!acc_we) rd_zero <= acc_err;
      end
    end
  end

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem_array (
    .clk  (clk),
    .en   (access && !acc_err),
    .we   (acc_we),
    .be   (acc_be),
    .idx  (acc_idx),
    .wdata(acc_wdata),
    .rdata(mem_rdata)
  );

  assign busy  = (state != IDLE);
  assign ack   = (state == RESP);
  assign err   = ack && err_q;
  assign rdata = rd_zero ? 32'h0 : mem_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: five instances at LATENCY 1, 0, 2, 3 and 15.
module tb_mem_responder;

  localparam int N = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req   [N];
  logic        we    [N];
  logic [31:0] addr  [N];
  logic [31:0] wdata [N];
  logic [3:0]  be    [N];
  logic        busy  [N];
  logic        ack   [N];
  logic [31:0] rdata [N];
  logic        err   [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(
      .DEPTH_WORDS(1024),
      .LATENCY    ((g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 2 : (g == 3) ? 3 : 15),
      .BASE_ADDR  (32'h0000_0000)
    ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req[g]),
      .we   (we[g]),
      .addr (addr[g]),
      .wdata(wdata[g]),
      .be   (be[g]),
      .busy (busy[g]),
      .ack  (ack[g]),
      .rdata(rdata[g]),
      .err  (err[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on instance k; lat counts cycles from the accepting cycle to the ack cycle.
  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input bit jitter,
                     output logic [31:0] rd, output logic e, output int lat);
    bit busy_ok;
    @(negedge clk);
    chk("idle_busy", 32'(busy[k]), 32'd0);
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
    lat = 0; rd = 'x; e = 1'bx; busy_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (busy[k] !== 1'b1) busy_ok = 1'b0;
      if (ack[k] === 1'b1) begin
        rd = rdata[k];
        e  = err[k];
      end else if (jitter) begin
        req[k] = ~req[k]; we[k] = ~we[k]; addr[k] = ~addr[k];
        wdata[k] = ~wdata[k]; be[k] = ~be[k];
      end else begin
        req[k] = 1'b0;
      end
    end while (ack[k] !== 1'b1 && lat < 40);
    req[k] = 1'b0;
    chk("busy_through_ack", 32'(busy_ok), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    bit          ack_seen;

    for (int i = 0; i < N; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0; be[i] = '0;
    end

    // Reset values
    @(negedge clk);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_ack", 32'(ack[0]), 32'd0);
    chk("rst_rdata", rdata[0], 32'h0);
    chk("rst_err", 32'(err[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Write then read, LATENCY=1
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, e, lat);
    chk("l1_wr_lat", 32'(lat), 32'd2);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, e, lat);
    chk("l1_rd_data", rd, 32'hDEAD_BEEF);
    chk("l1_rd_err", 32'(e), 32'd0);
    chk("l1_rd_lat", 32'(lat), 32'd2);

    // Byte lanes
    txn(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b0, rd, e, lat);
    txn(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, rd, e, lat);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd, e, lat);
    chk("be0101_data", rd, 32'h11BB_33DD);
    txn(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 1'b0, rd, e, lat);
    chk("be0000_err", 32'(e), 32'd0);
    chk("be0000_lat", 32'(lat), 32'd2);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd, e, lat);
    chk("be0000_data", rd, 32'h11BB_33DD);

    // Latency sweep
    txn(1, 1'b1, 32'h08, 32'h0102_0304, 4'hF, 1'b0, rd, e, lat);
    chk("l0_lat", 32'(lat), 32'd1);
    txn(1, 1'b0, 32'h08, 32'h0, 4'h0, 1'b0, rd, e, lat);
    chk("l0_rd_data", rd, 32'h0102_0304);
    txn(3, 1'b1, 32'h30, 32'h0000_0005, 4'hF, 1'b0, rd, e, lat);
    chk("l3_lat", 32'(lat), 32'd4);
    txn(4, 1'b1, 32'h04, 32'h55AA_55AA, 4'hF, 1'b0, rd, e, lat);
    chk("l15_lat", 32'(lat), 32'd16);
    txn(4, 1'b0, 32'h04, 32'h0, 4'h0, 1'b0, rd, e, lat);
    chk("l15_rd_data", rd, 32'h55AA_55AA);

    // Fields toggled during WAIT must not matter
    txn(2, 1'b1, 32'h40, 32'h0BAD_CAFE, 4'hF, 1'b1, rd, e, lat);
    chk("jitter_lat", 32'(lat), 32'd3);
    txn(2, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, rd, e, lat);
    chk("jitter_rd_data", rd, 32'h0BAD_CAFE);

    // req held high, LATENCY=2: one ack every 4 cycles
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h40;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("b2b_ack", 32'(ack[2]), (i % 4 == 3) ? 32'd1 : 32'd0);
      if (i % 4 == 3) chk("b2b_rdata", rdata[2], 32'h0BAD_CAFE);
      if (i == 12) req[2] = 1'b0;
    end

    // Reset during WAIT of a write to 0x30 (holds 0x5)
    @(negedge clk);
    req[3] = 1'b1; we[3] = 1'b1; addr[3] = 32'h30; wdata[3] = 32'hFFFF_FFFF; be[3] = 4'hF;
    @(negedge clk);
    req[3] = 1'b0;
    ack_seen = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy[3]), 32'd0);
    chk("midrst_ack", 32'(ack[3]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack[3] === 1'b1) ack_seen = 1'b1;
    end
    chk("midrst_no_ack", 32'(ack_seen), 32'd0);
    txn(3, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, rd, e, lat);
    chk("midrst_rd_data", rd, 32'h0000_0005);

    // Error handling
    txn(0, 1'b1, 32'h00, 32'h1234_5678, 4'hF, 1'b0, rd, e, lat);
    txn(0, 1'b0, 32'h13, 32'h0, 4'h0, 1'b0, rd, e, lat);
`ifdef MEM_RESPONDER_ERR_EN
    chk("misalign_rdata", rd, 32'h0);
    chk("misalign_err", 32'(e), 32'd1);
`else
    chk("misalign_rdata", rd, 32'hDEAD_BEEF);
    chk("misalign_err", 32'(e), 32'd0);
`endif
    txn(0, 1'b1, 32'h1000, 32'hCAFE_F00D, 4'hF, 1'b0, rd, e, lat);
`ifdef MEM_RESPONDER_ERR_EN
    chk("oob_wr_err", 32'(e), 32'd1);
`else
    chk("oob_wr_err", 32'(e), 32'd0);
`endif
    txn(0, 1'b0, 32'h00, 32'h0, 4'h0, 1'b0, rd, e, lat);
`ifdef MEM_RESPONDER_ERR_EN
    chk("oob_word0", rd, 32'h1234_5678);
`else
    chk("oob_word0", rd, 32'hCAFE_F00D);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
